// File: rtl/nvdla_tb_txn_gate_ctrl_if.sv
// Valid/ready bundle for the transaction gate: DUT payload stream in, comparator stream out.
interface nvdla_tb_txn_gate_ctrl_if #(
  parameter int PD_W = 8
);
  logic            rtl_valid;
  logic            rtl_ready;
  logic [PD_W-1:0] rtl_pd;
  logic            out_valid;
  logic            out_ready;
  logic [PD_W-1:0] out_pd;

  modport master (
    output rtl_valid, rtl_pd, out_ready,
    input  rtl_ready, out_valid, out_pd
  );

  modport slave (
    input  rtl_valid, rtl_pd, out_ready,
    output rtl_ready, out_valid, out_pd
  );
endinterface

// File: rtl/nvdla_tb_txn_gate_ctrl.sv
// Gates a DUT payload stream into the compare path according to the run's compare mode,
// with an IDLE/RUN/DRAIN run FSM, credit/ahead tracking and a one-entry output register.
module nvdla_tb_txn_gate_ctrl #(
  parameter int PD_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  nvdla_tb_txn_gate_ctrl_if.slave bus,
  input  logic [2:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_init_credit,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cmod_done,
  output logic [CNT_W-1:0]        credit,
  output logic [CNT_W-1:0]        txn_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cnt,
  output logic                    err_mode
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
  typedef enum logic [2:0] {
    MODE_NONE   = 3'd0,
    MODE_AHEAD  = 3'd1,
    MODE_GATING = 3'd2,
    MODE_LOOSE  = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  mode_e            r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_credit, w_credit_nxt;
  logic [CNT_W-1:0] r_txn_cnt, w_txn_cnt_nxt;
  logic             r_err_cnt, w_err_cnt_nxt;
  logic             r_err_mode, w_err_mode_nxt;
  logic             r_done, w_done_nxt;
  logic             r_buf_valid;
  logic [PD_W-1:0]  r_out_pd;

  logic w_run, w_gate_ok, w_rtl_ready, w_accept, w_cmod, w_mode_legal;

  assign w_run        = (r_state == ST_RUN);
  // Gating looks only at the registered credit; a cmod_done this cycle helps next cycle.
  assign w_gate_ok    = (r_mode != MODE_GATING) || (r_credit != '0);
  assign w_rtl_ready  = (r_mode == MODE_COUNT) ? w_run
                                               : (w_run && (!r_buf_valid || bus.out_ready) && w_gate_ok);
  assign w_accept     = bus.rtl_valid && w_rtl_ready;
  assign w_cmod       = cmod_done && (r_state != ST_IDLE);
  assign w_mode_legal = (cfg_mode >= 3'd1) && (cfg_mode <= 3'd4);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_credit_nxt   = r_credit;
    w_txn_cnt_nxt  = r_txn_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    w_err_mode_nxt = r_err_mode;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_mode_legal) begin
            w_mode_nxt    = mode_e'(cfg_mode);
            w_credit_nxt  = (cfg_mode == 3'd2) ? cfg_init_credit : '0;
            w_txn_cnt_nxt = '0;
            w_err_cnt_nxt = 1'b0;
            w_state_nxt   = ST_RUN;
          end else begin
            w_err_mode_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_buf_valid) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (r_state != ST_IDLE) begin
      if (w_accept) w_txn_cnt_nxt = r_txn_cnt + CNT_ONE;

      // Gating: credit counts C-model completions not yet matched by RTL accepts.
      if (r_mode == MODE_GATING) begin
        case ({w_cmod, w_accept})
          2'b10: begin
            if (r_credit == CNT_MAX) w_err_cnt_nxt = 1'b1;
            else                     w_credit_nxt  = r_credit + CNT_ONE;
          end
          2'b01:   w_credit_nxt = r_credit - CNT_ONE;
          default: w_credit_nxt = r_credit;
        endcase
      end else if (r_mode == MODE_AHEAD) begin
        case ({w_cmod, w_accept})
          2'b01: begin
            if (r_credit == CNT_MAX) w_err_cnt_nxt = 1'b1;
            else                     w_credit_nxt  = r_credit + CNT_ONE;
          end
          2'b10: begin
            if (r_credit == '0) w_err_cnt_nxt = 1'b1;
            else                w_credit_nxt  = r_credit - CNT_ONE;
          end
          default: w_credit_nxt = r_credit;
        endcase
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (nvdla_core_rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_NONE;
      r_credit   <= '0;
      r_txn_cnt  <= '0;
      r_err_cnt  <= 1'b0;
      r_err_mode <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_credit   <= w_credit_nxt;
      r_txn_cnt  <= w_txn_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_err_mode <= w_err_mode_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // One-entry output stage; count-only mode consumes payloads without loading it.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_buf_valid <= 1'b0;
      r_out_pd    <= '0;
    end else if (w_accept && (r_mode != MODE_COUNT)) begin
      r_buf_valid <= 1'b1;
      r_out_pd    <= bus.rtl_pd;
    end else if (bus.out_ready) begin
      r_buf_valid <= 1'b0;
    end
  end

  assign bus.rtl_ready = w_rtl_ready;
  assign bus.out_valid = r_buf_valid;
  assign bus.out_pd    = r_out_pd;
  assign credit        = r_credit;
  assign txn_cnt       = r_txn_cnt;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign err_cnt       = r_err_cnt;
  assign err_mode      = r_err_mode;

endmodule

// File: tb/tb_nvdla_tb_txn_gate_ctrl.sv
// Directed plus randomized bench for nvdla_tb_txn_gate_ctrl, checked cycle by cycle against
// a transaction-level model (run phase, integer credit arithmetic, expected-payload queue).
module tb_nvdla_tb_txn_gate_ctrl;
  localparam int     PD_W    = 8;
  localparam int     CNT_W   = 16;
  localparam longint CNT_MOD = longint'(1) << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_init_credit = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cmod_done = 1'b0;
  logic [CNT_W-1:0] credit;
  logic [CNT_W-1:0] txn_cnt;
  logic             busy, done, err_cnt, err_mode;

  nvdla_tb_txn_gate_ctrl_if #(.PD_W(PD_W)) bus ();

  nvdla_tb_txn_gate_ctrl #(.PD_W(PD_W), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .bus             (bus),
    .cfg_mode        (cfg_mode),
    .cfg_init_credit (cfg_init_credit),
    .start           (start),
    .stop            (stop),
    .cmod_done       (cmod_done),
    .credit          (credit),
    .txn_cnt         (txn_cnt),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .err_mode        (err_mode)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Model: phase 0=idle 1=running 2=draining; credit kept as an unbounded integer then clamped.
  int              m_phase;
  int              m_mode;
  longint          m_credit;
  longint          m_txn;
  bit              m_err_cnt, m_err_mode, m_done;
  logic [PD_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_mode     = 0;
    m_credit   = 0;
    m_txn      = 0;
    m_err_cnt  = 0;
    m_err_mode = 0;
    m_done     = 0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rtl_ready"}, 32'(bus.rtl_ready), 32'd0);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({pfx, "_out_pd"},    32'(bus.out_pd),    32'd0);
    check({pfx, "_credit"},    32'(credit),        32'd0);
    check({pfx, "_txn_cnt"},   32'(txn_cnt),       32'd0);
    check({pfx, "_busy"},      32'(busy),          32'd0);
    check({pfx, "_done"},      32'(done),          32'd0);
    check({pfx, "_err_cnt"},   32'(err_cnt),       32'd0);
    check({pfx, "_err_mode"},  32'(err_mode),      32'd0);
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances the model, then steps a clock.
  task automatic cycle();
    bit exp_ready;
    int acc, cmod_cnt, pre;
    #1;
    exp_ready = (m_phase == 1) &&
                ((m_mode == 4) ||
                 (((exp_q.size() == 0) || bus.out_ready) && ((m_mode != 2) || (m_credit != 0))));
    check("rtl_ready", 32'(bus.rtl_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_pd", 32'(bus.out_pd), 32'(exp_q[0]));
    check("credit",    32'(credit),   32'(m_credit));
    check("txn_cnt",   32'(txn_cnt),  32'(m_txn));
    check("busy",      32'(busy),     32'(m_phase != 0));
    check("done",      32'(done),     32'(m_done));
    check("err_cnt",   32'(err_cnt),  32'(m_err_cnt));
    check("err_mode",  32'(err_mode), 32'(m_err_mode));

    acc      = (bus.rtl_valid && exp_ready) ? 1 : 0;
    pre      = m_phase;
    cmod_cnt = (cmod_done && (pre != 0)) ? 1 : 0;
    m_done   = 0;

    if (pre == 0 && start) begin
      if (cfg_mode >= 3'd1 && cfg_mode <= 3'd4) begin
        m_mode    = int'(cfg_mode);
        m_credit  = (cfg_mode == 3'd2) ? longint'(cfg_init_credit) : 0;
        m_txn     = 0;
        m_err_cnt = 0;
        m_phase   = 1;
      end else begin
        m_err_mode = 1;
      end
    end else if (pre == 1 && stop) begin
      m_phase = 2;
    end else if (pre == 2 && exp_q.size() == 0) begin
      m_phase = 0;
      m_done  = 1;
    end

    if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
    if (acc != 0) begin
      m_txn = (m_txn + 1) % CNT_MOD;
      if (m_mode != 4) exp_q.push_back(bus.rtl_pd);
    end
    if (pre != 0) begin
      if (m_mode == 2)      m_credit = m_credit + cmod_cnt - acc;
      else if (m_mode == 1) m_credit = m_credit + acc - cmod_cnt;
      if (m_credit > CNT_MOD - 1) begin m_credit = CNT_MOD - 1; m_err_cnt = 1; end
      if (m_credit < 0)           begin m_credit = 0;           m_err_cnt = 1; end
    end

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [2:0] mode, input logic [CNT_W-1:0] init);
    cfg_mode        = mode;
    cfg_init_credit = init;
    start           = 1'b1;
    cycle();
    start           = 1'b0;
  endtask

  task automatic stop_and_drain(input int n);
    bus.rtl_valid = 1'b0;
    cmod_done     = 1'b0;
    stop          = 1'b1;
    cycle();
    stop          = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.rtl_valid = 1'b0;
    bus.rtl_pd    = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    cycle();

    // Mode 3: 10 back-to-back payloads, full throughput.
    bus.out_ready = 1'b1;
    start_run(3'd3, '0);
    for (int i = 0; i < 10; i++) begin
      bus.rtl_valid = 1'b1;
      bus.rtl_pd    = PD_W'(8'h30 + i);
      cycle();
    end
    bus.rtl_valid = 1'b0;
    cycle();
    check("m3_txn_cnt", 32'(txn_cnt), 32'd10);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();
    check("m3_done_pulse", 32'(done), 32'd1);
    cycle();
    check("m3_done_one_cycle", 32'(done), 32'd0);

    // Mode 2, credit 2: only two of five accepted until the C-model catches up.
    start_run(3'd2, 16'd2);
    bus.rtl_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rtl_pd = PD_W'($urandom);
      cycle();
    end
    check("m2_gated_txn", 32'(txn_cnt), 32'd2);
    check("m2_gated_ready", 32'(bus.rtl_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cmod_done = 1'b1;
      cycle();
      cmod_done = 1'b0;
      bus.rtl_pd = PD_W'($urandom);
      cycle();
    end
    bus.rtl_valid = 1'b0;
    cycle();
    check("m2_final_txn", 32'(txn_cnt), 32'd5);
    check("m2_final_credit", 32'(credit), 32'd0);
    stop_and_drain(3);

    // Mode 2, zero credit: cmod_done and rtl_valid together must not accept that cycle.
    start_run(3'd2, '0);
    bus.rtl_valid = 1'b1;
    bus.rtl_pd    = 8'h5a;
    cmod_done     = 1'b1;
    cycle();
    cmod_done     = 1'b0;
    check("m2z_credit_1", 32'(credit), 32'd1);
    check("m2z_txn_0", 32'(txn_cnt), 32'd0);
    cycle();
    check("m2z_credit_0", 32'(credit), 32'd0);
    check("m2z_txn_1", 32'(txn_cnt), 32'd1);
    stop_and_drain(3);

    // Mode 1: four accepts, then five completions; the fifth underflows.
    start_run(3'd1, 16'd7);
    for (int i = 0; i < 4; i++) begin
      bus.rtl_valid = 1'b1;
      bus.rtl_pd    = PD_W'($urandom);
      cycle();
    end
    bus.rtl_valid = 1'b0;
    check("m1_ahead_4", 32'(credit), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cmod_done = 1'b1;
      cycle();
    end
    check("m1_ahead_0", 32'(credit), 32'd0);
    check("m1_no_err_yet", 32'(err_cnt), 32'd0);
    cycle();
    cmod_done = 1'b0;
    check("m1_underflow_err", 32'(err_cnt), 32'd1);
    check("m1_underflow_hold", 32'(credit), 32'd0);
    stop_and_drain(3);

    // Mode 4: count only, out_ready low, nothing reaches the comparator.
    bus.out_ready = 1'b0;
    start_run(3'd4, 16'd9);
    for (int i = 0; i < 8; i++) begin
      bus.rtl_valid = 1'b1;
      bus.rtl_pd    = PD_W'($urandom);
      cycle();
    end
    check("m4_txn_cnt", 32'(txn_cnt), 32'd8);
    check("m4_out_valid", 32'(bus.out_valid), 32'd0);
    stop_and_drain(3);

    // Backpressure: buffered payload held through DRAIN until out_ready.
    start_run(3'd3, '0);
    bus.rtl_valid = 1'b1;
    bus.rtl_pd    = 8'ha5;
    cycle();
    bus.rtl_valid = 1'b0;
    bus.rtl_pd    = 8'h00;
    for (int i = 0; i < 3; i++) cycle();
    check("bp_out_pd_stable", 32'(bus.out_pd), 32'h0a5);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("bp_drain_busy", 32'(busy), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    check("bp_done", 32'(done), 32'd1);
    cycle();

    // Illegal mode at start.
    start_run(3'd5, '0);
    check("illegal_err_mode", 32'(err_mode), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    cycle();

    // Randomized runs across all legal modes.
    for (int r = 0; r < 4; r++) begin
      start_run(3'($urandom_range(1, 4)), CNT_W'($urandom_range(0, 3)));
      for (int i = 0; i < 150; i++) begin
        bus.rtl_valid = 1'($urandom_range(0, 1));
        bus.rtl_pd    = PD_W'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        cmod_done     = ($urandom_range(0, 3) == 0);
        start         = ($urandom_range(0, 15) == 0);
        cfg_mode      = 3'($urandom_range(0, 7));
        cycle();
      end
      start         = 1'b0;
      bus.out_ready = 1'b1;
      stop_and_drain(3);
    end

    // Reset in the middle of a run clears everything without waiting for an edge.
    bus.out_ready = 1'b0;
    start_run(3'd3, '0);
    bus.rtl_valid = 1'b1;
    bus.rtl_pd    = 8'h77;
    cycle();
    cycle();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    bus.rtl_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/nvdla_tb_txn_gate_ctrl.md
Name: nvdla_tb_txn_gate_ctrl

Overview:
- Transaction gating and sequencing controller between a DUT-side valid/ready stream (e.g. SDP/CACC output payloads) and the testbench compare path.
- Enforces the global compare mode per run:
  - RTL_AHEAD: passthrough; tracks how far the RTL is ahead of the C-model.
  - RTL_GATING_CMOD: credit-gated; the RTL may only pass as many transactions as the C-model has completed.
  - LOOSE_COMPARE: passthrough.
  - COUNT_TXN_ONLY: consumes and counts only.
- Has a start/stop/drain run FSM and a one-entry registered output stage.

Parameters:
- PD_W, 8, payload width (SDP_PW; 128 for large config).
- CNT_W, 16, width of the credit/ahead counter and the transaction counter.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rst  in  1  reset; asynchronous, active-high.
- cfg_mode  in  3  compare mode: 1=RTL_AHEAD, 2=RTL_GATING_CMOD, 3=LOOSE_COMPARE, 4=COUNT_TXN_ONLY.
- cfg_init_credit  in  CNT_W  initial credit; used in mode 2 only.
- start  in  1  run start pulse.
- stop  in  1  run stop pulse.
- cmod_done  in  1  one C-model transaction completed (1-cycle pulse).
- rtl_valid  in  1  DUT payload valid.
- rtl_ready  out  1  DUT payload accepted.
- rtl_pd  in  PD_W  DUT payload.
- out_valid  out  1  payload to comparator valid.
- out_ready  in  1  comparator ready.
- out_pd  out  PD_W  registered payload.
- credit  out  CNT_W  mode 2: remaining credit; mode 1: RTL-ahead count.
- txn_cnt  out  CNT_W  accepted RTL transaction count.
- busy  out  1  FSM not in IDLE.
- done  out  1  1-cycle pulse on DRAIN->IDLE.
- err_cnt  out  1  sticky; counter overflow or underflow.
- err_mode  out  1  sticky; illegal cfg_mode at start.

Behaviour:
- Reset (async): state IDLE, output buffer empty. All outputs 0, including out_pd, credit, txn_cnt, done and both err flags.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + start, cfg_mode in 1..4:
    - latch mode;
    - credit <= cfg_init_credit in mode 2, else 0;
    - txn_cnt <= 0;
    - err_cnt cleared;
    - go to RUN.
  - IDLE + start, illegal mode: set err_mode, stay IDLE.
  - IDLE + start + stop in the same cycle: start wins, stop ignored. stop alone in IDLE is ignored.
  - RUN + stop: go to DRAIN.
  - DRAIN: when the output buffer is empty, go to IDLE and pulse done for one cycle. If the buffer is already empty on entry, exit on the next cycle.
  - start outside IDLE is ignored. err_mode is cleared only by reset.
- Accept rules:
  - accept = rtl_valid & rtl_ready.
  - Modes 1-3: rtl_ready = (state==RUN) & (buf_empty | out_ready) & gate_ok.
  - gate_ok = (mode!=2) | (credit!=0). The registered credit is used, with no same-cycle bypass of cmod_done.
  - Mode 4: rtl_ready = (state==RUN). The payload is dropped and out_valid stays 0.
- stop in the same cycle as an accept: the accept completes. rtl_ready is 0 from the next cycle.
- Latency: an accepted payload appears on out_valid/out_pd in the next cycle.
  - The buffer holds until out_ready.
  - Full throughput (one transaction per cycle) when out_ready is held high.
  - out_pd is stable while out_valid & !out_ready.
- txn_cnt: +1 per accept, wraps modulo 2^CNT_W, no error on wrap.
- Counter updates (cmod_done is counted in RUN and DRAIN only):
  - Mode 2: credit_next = credit + cmod_done - accept. If cmod_done arrives at credit = 2^CNT_W-1 with no accept, credit saturates and err_cnt is set.
  - Mode 1: credit_next = credit + accept - cmod_done.
    - Increment at max: saturate, set err_cnt.
    - cmod_done at 0 with no accept: hold 0, set err_cnt.
  - Modes 3 and 4: credit holds 0; cmod_done is ignored.
- Reset mid-run: immediate return to IDLE; any buffered payload is discarded.

Test Plan:
- Mode 3: start, 10 back-to-back rtl_valid, out_ready=1 -> 10 outputs each 1 cycle after accept; payloads in order; txn_cnt=10; stop -> done pulse 2 cycles later.
- Mode 2, cfg_init_credit=2: 5 rtl transactions offered, no cmod_done -> exactly 2 accepted and rtl_ready stays 0. Then 3 cmod_done pulses -> remaining 3 accepted; final credit=0, txn_cnt=5.
- Mode 2, credit=0, cmod_done and rtl_valid in the same cycle -> no accept that cycle; accept on the next cycle; credit goes 0->1->0.
- Mode 1: 4 accepts, then 5 cmod_done -> credit 4->0; err_cnt set on the 5th pulse; credit stays 0.
- Mode 4: 8 rtl transactions, out_ready=0 -> all accepted at 1/cycle; out_valid never asserted; txn_cnt=8.
- Backpressure and reset: out_ready=0 with one buffered payload -> out_pd stable; stop -> state held in DRAIN until out_ready=1, then done. Separately, cfg_mode=5 at start -> err_mode=1 and busy=0; reset asserted mid-RUN -> all outputs 0 immediately.
